grid_cursor: RTL

Parametrised cursor-position controller for an arbitrary ROWS x COLS board. It is the generalised successor of the fixed 3x3 grid mover. It adds:
- press-edge moves with hold-to-auto-repeat timing
- selectable wrap-around or clamp-at-edge mode
- pause enable and direct position load
- move/bump event pulses
Game FSM and renderer consume its row, col and linear index outputs.

---
 rtl/grid_pkg.sv | 12 +
 rtl/dir_repeat_ctrl.sv | 62 ++++++
 rtl/grid_cursor.sv | 78 +++++++
 3 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: direction codes, FSM state type and width helper shared by the grid cursor blocks
package grid_pkg;
  localparam logic [2:0] DIR_IDLE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dir_repeat_ctrl.sv
// dir_repeat_ctrl: press/hold/auto-repeat sequencer turning a held direction into step strobes
module dir_repeat_ctrl
  import grid_pkg::*;
#(
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] dir,
  output logic       step_valid,
  output logic [2:0] step_dir
);
  localparam int TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = clog2_min1(TMAX);
  localparam logic [TW-1:0] LIM_D = TW'(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] LIM_P = TW'(REPEAT_PERIOD > 0 ? REPEAT_PERIOD - 1 : 0);
  state_t st, st_n;
  logic [TW-1:0] tmr, tmr_n, lim;
  logic [2:0] lat, lat_n, d;
  logic hold_only;
  assign d = dir > DIR_LEFT ? DIR_IDLE : dir;
  assign lim = st == ST_HOLD ? LIM_D : LIM_P;
  assign hold_only = st == ST_HOLD && REPEAT_DELAY == 0;
  assign step_dir = d;
  always_comb begin
    st_n = st;
    tmr_n = tmr;
    lat_n = lat;
    step_valid = 1'b0;
    if (st == ST_IDLE || (d != DIR_IDLE && d != lat)) begin
      if (d != DIR_IDLE) begin
        step_valid = 1'b1;
        lat_n = d;
        tmr_n = '0;
        st_n = ST_HOLD;
      end
    end else if (d == DIR_IDLE) begin
      st_n = ST_IDLE;
      tmr_n = '0;
      lat_n = DIR_IDLE;
    end else if (!hold_only) begin
      step_valid = tmr == lim;
      tmr_n = tmr == lim ? '0 : tmr + TW'(1);
      st_n = tmr == lim ? ST_REPEAT : st;
    end
    step_valid = step_valid & en & ~clr;
  end
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      st <= ST_IDLE;
      tmr <= '0;
      lat <= DIR_IDLE;
    end else if (en) begin
      st <= st_n;
      tmr <= tmr_n;
      lat <= lat_n;
    end
  end
endmodule

// File: rtl/grid_cursor.sv
// grid_cursor: ROWS x COLS cursor with auto-repeat stepping, clamp or wrap edges, pause and direct load
module grid_cursor
  import grid_pkg::*;
#(
  parameter int ROWS          = 3,
  parameter int COLS          = 3,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4,
  localparam int RW = clog2_min1(ROWS),
  localparam int CW = clog2_min1(COLS),
  localparam int IW = clog2_min1(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [2:0]    dir,
  input  logic          load_en,
  input  logic [RW-1:0] load_row,
  input  logic [CW-1:0] load_col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [IW-1:0] index,
  output logic          moved,
  output logic          bumped
);
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
  logic step_valid, up, dn, rt, lf, hit;
  logic [2:0] step_dir;
  logic [RW-1:0] nr;
  logic [CW-1:0] nc;
  dir_repeat_ctrl #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rep (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .clr       (load_en),
    .dir       (dir),
    .step_valid(step_valid),
    .step_dir  (step_dir)
  );
  assign up = step_dir == DIR_UP;
  assign dn = step_dir == DIR_DOWN;
  assign rt = step_dir == DIR_RIGHT;
  assign lf = step_dir == DIR_LEFT;
  assign hit = (up && row == '0) || (dn && row == RMAX) || (lf && col == '0) || (rt && col == CMAX);
  assign nr = up ? (row == '0 ? RMAX : row - RW'(1)) : dn ? (row == RMAX ? '0 : row + RW'(1)) : row;
  assign nc = lf ? (col == '0 ? CMAX : col - CW'(1)) : rt ? (col == CMAX ? '0 : col + CW'(1)) : col;
  assign index = IW'(row) * IW'(COLS) + IW'(col);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row <= '0;
      col <= '0;
      moved <= 1'b0;
      bumped <= 1'b0;
    end else if (load_en) begin
      row <= load_row > RMAX ? RMAX : load_row;
      col <= load_col > CMAX ? CMAX : load_col;
      moved <= 1'b0;
      bumped <= 1'b0;
    end else begin
      moved <= 1'b0;
      bumped <= 1'b0;
      if (step_valid) begin
        if (hit && WRAP == 0) begin
          bumped <= 1'b1;
        end else begin
          row <= nr;
          col <= nc;
          moved <= nr != row || nc != col;
        end
      end
    end
  end
endmodule
